dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of all data buses.
REQ-002 Parameter ADDR_W, default 9, word address width of the data memory.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 c_req  input  1  core memory request, held with command until c_gnt.
REQ-006 c_we  input  1  core command: 1 write, 0 read.
REQ-007 c_addr  input  ADDR_W  core word address.
REQ-008 c_wdata  input  DATA_W  core write data.
REQ-009 c_gnt  output  1  core command accepted this cycle.
REQ-010 c_rvalid  output  1  rdata holds core read result this cycle.
REQ-011 d_req  input  1  debug/loader memory request, held with command until d_gnt.
REQ-012 d_we  input  1  debug command: 1 write, 0 read.
REQ-013 d_addr  input  ADDR_W  debug word address.
REQ-014 d_wdata  input  DATA_W  debug write data.
REQ-015 d_lock  input  1  debug requests exclusive ownership while high.
REQ-016 d_gnt  output  1  debug command accepted this cycle.
REQ-017 d_rvalid  output  1  rdata holds debug read result this cycle.
REQ-018 rdata  output  DATA_W  shared read data; equals mem_rdata when either rvalid is high, else 0.
REQ-019 mem_wr / mem_rd  output  1 each  registered write/read strobes to the synchronous RAM.
REQ-020 mem_addr / mem_wdata  output  ADDR_W / DATA_W  registered address and write data to the RAM.
REQ-021 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_rd.

Function
REQ-022 Arbitration is combinational in cycle N: at most one of c_gnt/d_gnt is high, and a gnt is high only when its req is high.
REQ-023 The granted command is registered at the end of cycle N; mem_wr or mem_rd is high for exactly cycle N+1 with mem_addr/mem_wdata from the granted requester.
REQ-024 A read granted in cycle N raises the owner's rvalid in cycle N+2 only; writes produce no rvalid.
REQ-025 Throughput is one grant per cycle; back-to-back grants to either requester are allowed.
REQ-026 A register rr_last records the last granted requester; when both req are high in state RR, the requester other than rr_last wins.
REQ-027 The FSM has states RR and LOCK; it resets to RR.
REQ-028 RR->LOCK when d_gnt is high and d_lock is high in the same cycle.
REQ-029 In LOCK, c_gnt is 0 and d_gnt equals d_req; LOCK->RR on the first cycle d_lock is low, and arbitration in that cycle uses RR rules.
REQ-030 A request whose req is low is ignored; the arbiter never latches or replays a withdrawn request.
REQ-031 In idle cycles (no grant) mem_wr and mem_rd are 0, and mem_addr/mem_wdata hold their previous values.

Reset
REQ-032 While reset is low: state is RR, rr_last is debug (core wins first tie), and mem_wr, mem_rd, c_rvalid, d_rvalid, rdata, mem_addr and mem_wdata are 0.
REQ-033 While reset is low, c_gnt and d_gnt are 0; reset asserted mid-access drops any pending read response without an rvalid pulse.

Structure
REQ-034 A shared package holds the FSM state enum {RR, LOCK}, the requester-id enum {REQ_CORE, REQ_DBG} and the default ADDR_W/DATA_W constants.
REQ-035 The fixed-priority-with-pointer selector is a sub-module named rr_pick2; everything else is flat.

Verification
REQ-036 Core only: core read of 0x05 with RAM[0x05]=0xDEADBEEF -> c_gnt in cycle 0, mem_rd with mem_addr=0x05 in cycle 1, c_rvalid with rdata=0xDEADBEEF in cycle 2.
REQ-037 Tie after reset: both req high in cycle 0 -> core granted in cycle 0, debug in cycle 1, core in cycle 2 while both remain requesting.
REQ-038 Lock: debug write 0x10<=0x1234 with d_lock=1 and core requesting -> c_gnt stays 0 for all 4 lock cycles; first core grant occurs in the cycle d_lock falls.
REQ-039 Back-to-back: debug writes 0x01<=0xA, then reads 0x01 in consecutive cycles -> mem_wr in cycle 1, mem_rd in cycle 2, d_rvalid with rdata=0xA in cycle 3.
REQ-040 Reset mid-read: reset is asserted in the cycle after a core grant -> no c_rvalid occurs, all outputs are 0, and the first post-reset tie goes to the core.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 9;

    typedef enum logic {
        RR   = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_pick2 (
    input  logic c_req,
    input  logic d_req,
    input  logic last_dbg,
    output logic pick_c,
    output logic pick_d
);

    // Tie broken by the last-granted pointer; outputs are mutually exclusive.
    always_comb begin
        pick_c = c_req & (~d_req | last_dbg);
        pick_d = d_req & (~c_req | ~last_dbg);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core and the debug/loader port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RR    | round-robin between core and debug, one grant per cycle
//   LOCK  | debug owns the memory while d_lock stays high; core is blocked
//
// Grants are combinational in cycle N, the RAM command is registered into
// cycle N+1, and read data comes back with rvalid in cycle N+2.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state;
    req_id_e    rr_last;
    logic       lock_hold;
    logic       pick_c;
    logic       pick_d;
    logic       pend_c;
    logic       pend_d;

    // Lock only holds while d_lock is still high; the release cycle already
    // arbitrates with round-robin rules.
    assign lock_hold = (state == LOCK) && d_lock;

    rr_pick2 u_pick (
        .c_req    (c_req),
        .d_req    (d_req),
        .last_dbg (rr_last == REQ_DBG),
        .pick_c   (pick_c),
        .pick_d   (pick_d)
    );

    // Grant decode; gated by reset so nothing is accepted while held in reset.
    always_comb begin
        c_gnt = reset & ~lock_hold & pick_c;
        d_gnt = reset & (lock_hold ? d_req : pick_d);
    end

    // Arbitration FSM and last-granted pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RR;
            rr_last <= REQ_DBG;
        end else begin
            if (c_gnt) begin
                rr_last <= REQ_CORE;
            end else if (d_gnt) begin
                rr_last <= REQ_DBG;
            end

            case (state)
                RR: begin
                    if (d_gnt && d_lock) begin
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (!d_lock) begin
                        state <= RR;
                    end
                end
                default: state <= RR;
            endcase
        end
    end

    // Register the granted command toward the RAM; address/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wr <= (c_gnt & c_we) | (d_gnt & d_we);
            mem_rd <= (c_gnt & ~c_we) | (d_gnt & ~d_we);
            if (c_gnt) begin
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
            end else if (d_gnt) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end
        end
    end

    // Track read ownership alongside the RAM access so rvalid lines up with mem_rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_c   <= 1'b0;
            pend_d   <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            pend_c   <= c_gnt & ~c_we;
            pend_d   <= d_gnt & ~d_we;
            c_rvalid <= pend_c;
            d_rvalid <= pend_d;
        end
    end

    // Shared read bus is quiet unless a response is being returned.
    assign rdata = (c_rvalid | d_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a scoreboard of expected
// RAM strobes and read responses, checked by a negedge monitor.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] rdata;
    logic          mem_wr, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM model with one-cycle read latency.
    logic [DW-1:0] ram [512];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        ram[9'h005] = 32'hDEADBEEF;
        ram[9'h020] = 32'h0000_2020;
        ram[9'h021] = 32'h0000_2121;
        ram[9'h030] = 32'h0000_3030;
    end
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    typedef struct {
        int            cyc;
        bit            dbg;
        logic [DW-1:0] data;
    } rd_exp_t;

    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_mem(int c, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        mem_exp_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.data = d;
        mem_q.push_back(e);
    endtask

    task automatic push_rd(int c, bit dbg, logic [DW-1:0] d);
        rd_exp_t e;
        e.cyc = c; e.dbg = dbg; e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe and response must match the queue head.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_wr || mem_rd) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 32'(mem_wr | mem_rd), 32'd0);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    chk("mem_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mem_wr", 32'(mem_wr), 32'(e.wr));
                    chk("mem_rd", 32'(mem_rd), 32'(!e.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.wr) chk("mem_wdata", mem_wdata, e.data);
                end
            end else if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
                void'(mem_q.pop_front());
                chk("mem_missing", 32'd0, 32'd1);
            end

            if (c_rvalid || d_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(c_rvalid | d_rvalid), 32'd0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(r.cyc));
                    chk("rd_c_rvalid", 32'(c_rvalid), 32'(!r.dbg));
                    chk("rd_d_rvalid", 32'(d_rvalid), 32'(r.dbg));
                    chk("rd_rdata", rdata, r.data);
                end
            end else begin
                chk("rdata_idle", rdata, 32'd0);
                if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                    void'(rd_q.pop_front());
                    chk("rd_missing", 32'd0, 32'd1);
                end
            end
        end
    end

    task automatic chk_all_zero(string tag);
        chk({tag, "_c_gnt"}, 32'(c_gnt), 32'd0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_c_rvalid"}, 32'(c_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b1;

        // Reset state: requests held high must still see no grant.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Core-only read of 0x05.
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
        push_mem(cyc + 1, 1'b0, 9'h005, '0);
        push_rd(cyc + 2, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_c_gnt", 32'(c_gnt), 32'd1);
        chk("t1_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_rd", 32'(mem_rd), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h005);
        tick();
        @(negedge clk);
        chk("t1_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        tick();

        // Tie after reset alternates core, debug, core.
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h021;
        push_mem(cyc + 1, 1'b0, 9'h020, '0);
        push_rd(cyc + 2, 1'b0, 32'h2020);
        @(negedge clk);
        chk("t2_c0_c_gnt", 32'(c_gnt), 32'd1);
        chk("t2_c0_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        push_mem(cyc + 1, 1'b0, 9'h021, '0);
        push_rd(cyc + 2, 1'b1, 32'h2121);
        @(negedge clk);
        chk("t2_c1_c_gnt", 32'(c_gnt), 32'd0);
        chk("t2_c1_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        push_mem(cyc + 1, 1'b0, 9'h020, '0);
        push_rd(cyc + 2, 1'b0, 32'h2020);
        @(negedge clk);
        chk("t2_c2_c_gnt", 32'(c_gnt), 32'd1);
        chk("t2_c2_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        c_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();

        // Lock: debug owns memory for four cycles while the core waits on 0x30.
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'h1234; d_lock = 1'b1;
        push_mem(cyc + 1, 1'b1, 9'h010, 32'h1234);
        @(negedge clk);
        chk("t3_l0_c_gnt", 32'(c_gnt), 32'd0);
        chk("t3_l0_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_we = 1'b0;
        push_mem(cyc + 1, 1'b0, 9'h010, '0);
        push_rd(cyc + 2, 1'b1, 32'h1234);
        @(negedge clk);
        chk("t3_l1_c_gnt", 32'(c_gnt), 32'd0);
        chk("t3_l1_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("t3_l2_c_gnt", 32'(c_gnt), 32'd0);
        chk("t3_l2_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h011; d_wdata = 32'h55;
        push_mem(cyc + 1, 1'b1, 9'h011, 32'h55);
        @(negedge clk);
        chk("t3_l3_c_gnt", 32'(c_gnt), 32'd0);
        chk("t3_l3_d_gnt", 32'(d_gnt), 32'd1);
        chk("t3_idle_hold_addr", 32'(mem_addr), 32'h010);
        chk("t3_idle_no_strobe", 32'(mem_wr | mem_rd), 32'd0);
        tick();
        d_req = 1'b0; d_lock = 1'b0;
        push_mem(cyc + 1, 1'b0, 9'h030, '0);
        push_rd(cyc + 2, 1'b0, 32'h3030);
        @(negedge clk);
        chk("t3_release_c_gnt", 32'(c_gnt), 32'd1);
        chk("t3_release_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        c_req = 1'b0;
        repeat (3) tick();

        // Back-to-back debug write then read of 0x01.
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h001; d_wdata = 32'hA;
        push_mem(cyc + 1, 1'b1, 9'h001, 32'hA);
        @(negedge clk);
        chk("t4_c0_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_we = 1'b0;
        push_mem(cyc + 1, 1'b0, 9'h001, '0);
        push_rd(cyc + 2, 1'b1, 32'hA);
        @(negedge clk);
        chk("t4_c1_d_gnt", 32'(d_gnt), 32'd1);
        chk("t4_c1_mem_wr", 32'(mem_wr), 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("t4_c2_mem_rd", 32'(mem_rd), 32'd1);
        tick();
        @(negedge clk);
        chk("t4_c3_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("t4_c3_rdata", rdata, 32'hA);
        tick();
        repeat (2) tick();

        // Reset mid-read: the pending core read must vanish.
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
        @(negedge clk);
        chk("t6_c_gnt", 32'(c_gnt), 32'd1);
        tick();
        c_req = 1'b0;
        reset = 1'b0;
        #1;
        chk_all_zero("t6_mid");
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_c_rvalid", 32'(c_rvalid), 32'd0);
        end
        reset = 1'b1;
        tick();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h021;
        push_mem(cyc + 1, 1'b0, 9'h005, '0);
        push_rd(cyc + 2, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t6_tie_c_gnt", 32'(c_gnt), 32'd1);
        chk("t6_tie_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        c_req = 1'b0; d_req = 1'b0;

        repeat (5) tick();
        chk("drain_mem_q", 32'(mem_q.size()), 32'd0);
        chk("drain_rd_q", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
